jtdsp16_qsnd_host: RTL and testbench
====================================

Name: jtdsp16_qsnd_host

Overview:
- Host-command bridge between the sound CPU (Z80) and the DSP16 parallel I/O port.
- The host writes a 16-bit data word and an 8-bit register address. This raises irq to the DSP.
- The DSP fetches address and data through pbus_in using psel/pids_n. Completion sets the host-visible ready flag.
- Sits directly upstream of the DSP core:
  - drives its irq and pbus_in;
  - consumes its pids_n, psel and cen_cko.

Parameters:
- ADDR_W, 8: width of the register-address latch. Zero-extended to 16 bits on pbus_in.
- RDY_BIT, 7: bit position of the ready flag in the host status byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  DSP clock enable (the core's cen_cko). All DSP-side strobe sampling is gated by it.
- cpu_a  in  2  host register select: 0 = data high, 1 = data low, 2 = address/trigger, 3 = reserved.
- cpu_din  in  8  host write data.
- cpu_we  in  1  host write strobe. One clk wide, not gated by cen.
- cpu_rd  in  1  host status-read strobe. One clk wide.
- cpu_dout  out  8  status byte:
  - bit RDY_BIT = ready;
  - bit 0 = overrun;
  - all other bits 0.
- irq  out  1  interrupt request to the DSP.
- psel  in  1  DSP peripheral select: 0 = address, 1 = data.
- pids_n  in  1  DSP parallel input strobe, active low.
- pbus_in  out  16  word presented to the DSP.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, ready = 1, overrun = 0, irq = 0;
  - data latch = 0, address latch = 0, pbus_in = 0, cpu_dout = 8'h80 (default RDY_BIT).
- Host writes (every clk with cpu_we, regardless of state):
  - a=0 → stage_hi <= cpu_din;
  - a=1 → stage_lo <= cpu_din;
  - a=3 → ignored.
- Address write (a=2):
  - In IDLE:
    - addr latch <= cpu_din[ADDR_W-1:0] and data latch <= {stage_hi, stage_lo}, in the same clk;
    - ready <= 0, irq <= 1, state <= PEND. Visible the next clk.
  - Otherwise: write dropped, latches unchanged, overrun <= 1.
- Status read: cpu_rd returns the current status byte combinationally. overrun clears on the clk after cpu_rd.
  - If cpu_rd coincides with an overrun-setting write, overrun stays 1 (set wins).
- pbus_in = psel ? data latch : {zero-extended addr latch}. Combinational from the latches, valid in every state.
- DSP strobe handling:
  - pids_n registered on cen cycles only (pids_l).
  - A read completes on a cen cycle where pids_l = 0 and pids_n = 1 (rising edge).
- FSM, advancing only on cen for DSP events:
  - PEND: address read complete (psel=0) → ADDR, irq <= 0. A data read in PEND is legal and ignored (state holds).
  - ADDR: data read complete (psel=1) → IDLE, ready <= 1. An extra address read in ADDR is ignored.
  - IDLE: DSP reads are harmless and return the latched values.
- irq is a level, high in PEND only.
- Latency:
  - host address write → irq = 1: one clk.
  - final pids_n rise → ready = 1: one clk after that cen.
- Address write on the same clk as completion (the ADDR→IDLE edge): treated as busy, i.e. dropped with overrun = 1.
- Staging registers may be rewritten while busy; this does not disturb the latched transaction.
- Reset mid-transaction: immediate return to IDLE, irq drops asynchronously, ready = 1.
- cen low: DSP-side state frozen; host writes still accepted into staging.
- No other outputs change on cen = 0 cycles except through host strobes.

Test Plan:
- Reset → cpu_dout = 8'h80, irq = 0, pbus_in = 0 with psel = 0 and with psel = 1.
- Write 0x12 to a0, 0x34 to a1, 0x5A to a2 → next clk irq = 1, status 8'h00.
  - psel = 0 gives pbus_in = 16'h005A; psel = 1 gives 16'h1234.
- Same transaction: pids_n pulse with psel = 0 → irq = 0, ready still 0.
  - Then pids_n pulse with psel = 1 → status 8'h80 one clk after the rising cen.
- While in PEND: write a0 = 0xFF, then a2 = 0x77 → pbus_in data still 16'h1234, addr still 0x5A, status 8'h01.
  - cpu_rd → overrun cleared; status 8'h00 the next clk.
- cen held low during a pids_n pulse → no state change, irq stays 1.
  - Repeat with cen toggling → normal completion.
- Assert rst_n low in ADDR state → irq = 0 and cpu_dout = 8'h80 without waiting for a clk edge.
  - A new 3-byte command after release proceeds normally.

Source files
------------

// File: rtl/jtdsp16_qsnd_host.sv
// Host-command bridge between the sound CPU and the DSP16 parallel input port.
// The CPU stages a 16-bit data word and then writes an address byte. That write
// latches the transaction and raises irq. The DSP then reads the address
// (psel=0) and the data (psel=1) through pbus_in. After the data read the bridge
// reports ready again.
module jtdsp16_qsnd_host #(
  parameter int ADDR_W  = 8,
  parameter int RDY_BIT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [1:0]  cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic        irq,
  input  logic        psel,
  input  logic        pids_n,
  output logic [15:0] pbus_in
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ADDR = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [7:0]          r_stage_hi;
  logic [7:0]          r_stage_lo;
  logic [15:0]         r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_overrun;
  logic                r_pids_l;

  logic                w_addr_wr;
  logic                w_accept;
  logic                w_rd_done;
  logic                w_ready;

  // An address write is only taken while idle. Any other address write is a
  // host overrun. This includes a write on the clk where the final DSP read
  // completes, because the state is still ADDR on that edge.
  assign w_addr_wr = cpu_we && (cpu_a == 2'd2);
  assign w_accept  = w_addr_wr && (r_state == ST_IDLE);

  // A DSP read completes when pids_n rises. The edge is only seen on cen cycles.
  assign w_rd_done = cen && !r_pids_l && pids_n;

  // ready means no transaction is outstanding. irq is a pure level of PEND.
  // Both come from the state register, so an async reset clears them at once.
  assign w_ready = (r_state == ST_IDLE);
  assign irq     = (r_state == ST_PEND);

  // Present a latched value to the DSP. psel chooses the data word or the
  // zero-extended address.
  assign pbus_in = psel ? r_data : 16'(r_addr);

  // Build the host status byte.
  always_comb begin
    cpu_dout          = 8'h00;
    cpu_dout[RDY_BIT] = w_ready;
    cpu_dout[0]       = r_overrun;
  end

  // Update the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Compute the next state. DSP events only count on cen cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)            w_state_nxt = ST_PEND;
      ST_PEND: if (w_rd_done && !psel)  w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_rd_done &&  psel)  w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Register the DSP input strobe on cen cycles only. This gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_pids_l <= 1'b1;
    else if (cen) r_pids_l <= pids_n;
  end

  // Capture the host staging bytes. They may be rewritten at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_hi <= 8'h00;
      r_stage_lo <= 8'h00;
    end else if (cpu_we) begin
      if (cpu_a == 2'd0) r_stage_hi <= cpu_din;
      if (cpu_a == 2'd1) r_stage_lo <= cpu_din;
    end
  end

  // Latch the transaction when an address write is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 16'h0000;
      r_addr <= '0;
    end else if (w_accept) begin
      r_data <= {r_stage_hi, r_stage_lo};
      r_addr <= cpu_din[ADDR_W-1:0];
    end
  end

  // Track overrun. A new overrun takes priority over a clear by a status read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_overrun <= 1'b0;
    else if (w_addr_wr && !w_accept)  r_overrun <= 1'b1;
    else if (cpu_rd)                  r_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_jtdsp16_qsnd_host.sv
// Directed bench for the host-command bridge. Inputs change 1ns after the rising
// edge. Outputs are checked before the next rising edge.
`timescale 1ns/1ps
module tb_jtdsp16_qsnd_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [1:0]  cpu_a;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        irq;
  logic        psel;
  logic        pids_n;
  logic [15:0] pbus_in;

  int total = 0;
  int bad   = 0;

  jtdsp16_qsnd_host #(.ADDR_W(8), .RDY_BIT(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .cpu_a    (cpu_a),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .cpu_rd   (cpu_rd),
    .cpu_dout (cpu_dout),
    .irq      (irq),
    .psel     (psel),
    .pids_n   (pids_n),
    .pbus_in  (pbus_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    cpu_a = a; cpu_din = d; cpu_we = 1'b1;
    cyc();
    cpu_we = 1'b0;
  endtask

  task automatic status_rd();
    cpu_rd = 1'b1;
    cyc();
    cpu_rd = 1'b0;
  endtask

  // Full-rate DSP read: pids_n low for one clk, then high for one clk, with cen=1.
  task automatic dsp_rd(input logic sel);
    psel = sel; pids_n = 1'b0;
    cyc();
    pids_n = 1'b1;
    cyc();
  endtask

  // DSP read with cen toggling. The rising pids_n edge is sampled on the last cen.
  task automatic dsp_rd_slow(input logic sel);
    psel = sel; pids_n = 1'b0; cen = 1'b0;
    cyc();
    cen = 1'b1;
    cyc();
    cen = 1'b0; pids_n = 1'b1;
    cyc();
    cen = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cen = 1'b1; cpu_a = 2'd0; cpu_din = 8'h00; cpu_we = 1'b0;
    cpu_rd = 1'b0; psel = 1'b0; pids_n = 1'b1;
    cyc(); cyc();
    chk("rst_dout", {8'h0, cpu_dout}, 16'h0080);
    chk("rst_irq", {15'h0, irq}, 16'h0);
    psel = 1'b0; #1 chk("rst_pbus_a", pbus_in, 16'h0000);
    psel = 1'b1; #1 chk("rst_pbus_d", pbus_in, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // Basic transaction
    host_wr(2'd0, 8'h12);
    host_wr(2'd1, 8'h34);
    chk("stage_irq0", {15'h0, irq}, 16'h0);
    host_wr(2'd2, 8'h5A);
    chk("cmd_irq", {15'h0, irq}, 16'h1);
    chk("cmd_dout", {8'h0, cpu_dout}, 16'h0000);
    psel = 1'b0; #1 chk("cmd_pbus_a", pbus_in, 16'h005A);
    psel = 1'b1; #1 chk("cmd_pbus_d", pbus_in, 16'h1234);
    dsp_rd(1'b1);
    chk("pend_data_rd_irq", {15'h0, irq}, 16'h1);
    dsp_rd(1'b0);
    chk("addr_rd_irq", {15'h0, irq}, 16'h0);
    chk("addr_rd_dout", {8'h0, cpu_dout}, 16'h0000);
    dsp_rd(1'b0);
    chk("addr_extra_dout", {8'h0, cpu_dout}, 16'h0000);
    psel = 1'b1; pids_n = 1'b0;
    cyc();
    pids_n = 1'b1;
    #1 chk("pre_done_dout", {8'h0, cpu_dout}, 16'h0000);
    cyc();
    chk("done_dout", {8'h0, cpu_dout}, 16'h0080);

    // Overrun while pending
    host_wr(2'd2, 8'h5A);
    host_wr(2'd0, 8'hFF);
    host_wr(2'd2, 8'h77);
    psel = 1'b1; #1 chk("ovr_pbus_d", pbus_in, 16'h1234);
    psel = 1'b0; #1 chk("ovr_pbus_a", pbus_in, 16'h005A);
    chk("ovr_dout", {8'h0, cpu_dout}, 16'h0001);
    cpu_rd = 1'b1;
    #1 chk("ovr_rd_dout", {8'h0, cpu_dout}, 16'h0001);
    cyc();
    cpu_rd = 1'b0;
    chk("ovr_clr_dout", {8'h0, cpu_dout}, 16'h0000);
    cpu_rd = 1'b1;
    host_wr(2'd2, 8'h11);
    cpu_rd = 1'b0;
    chk("set_wins_dout", {8'h0, cpu_dout}, 16'h0001);
    status_rd();
    chk("set_wins_clr", {8'h0, cpu_dout}, 16'h0000);

    // cen held low freezes the DSP side
    cen = 1'b0; psel = 1'b0; pids_n = 1'b0;
    cyc(); cyc();
    pids_n = 1'b1;
    cyc(); cyc();
    chk("cen_low_irq", {15'h0, irq}, 16'h1);
    cen = 1'b1;
    cyc();
    chk("cen_low_irq2", {15'h0, irq}, 16'h1);
    dsp_rd_slow(1'b0);
    chk("slow_addr_irq", {15'h0, irq}, 16'h0);
    chk("slow_addr_dout", {8'h0, cpu_dout}, 16'h0000);
    dsp_rd_slow(1'b1);
    chk("slow_data_dout", {8'h0, cpu_dout}, 16'h0080);
    psel = 1'b1; #1 chk("idle_pbus_d", pbus_in, 16'h1234);

    // Address write on the completion clk counts as busy
    host_wr(2'd2, 8'h66);
    psel = 1'b1; #1 chk("cmd2_pbus_d", pbus_in, 16'hFF34);
    psel = 1'b0; #1 chk("cmd2_pbus_a", pbus_in, 16'h0066);
    dsp_rd(1'b0);
    psel = 1'b1; pids_n = 1'b0;
    cyc();
    pids_n = 1'b1; cpu_a = 2'd2; cpu_din = 8'h22; cpu_we = 1'b1;
    cyc();
    cpu_we = 1'b0;
    chk("edge_wr_dout", {8'h0, cpu_dout}, 16'h0081);
    psel = 1'b0; #1 chk("edge_wr_pbus_a", pbus_in, 16'h0066);
    status_rd();
    chk("edge_wr_clr", {8'h0, cpu_dout}, 16'h0080);

    // Async reset in ADDR state, then a fresh command
    host_wr(2'd2, 8'h44);
    chk("cmd3_irq", {15'h0, irq}, 16'h1);
    dsp_rd(1'b0);
    chk("cmd3_addr_dout", {8'h0, cpu_dout}, 16'h0000);
    #2 rst_n = 1'b0;
    #1 chk("arst_dout", {8'h0, cpu_dout}, 16'h0080);
    chk("arst_irq", {15'h0, irq}, 16'h0);
    psel = 1'b1; #1 chk("arst_pbus_d", pbus_in, 16'h0000);
    cyc();
    rst_n = 1'b1;
    cyc();
    host_wr(2'd0, 8'hAB);
    host_wr(2'd1, 8'hCD);
    host_wr(2'd2, 8'h3C);
    chk("post_irq", {15'h0, irq}, 16'h1);
    psel = 1'b1; #1 chk("post_pbus_d", pbus_in, 16'hABCD);
    psel = 1'b0; #1 chk("post_pbus_a", pbus_in, 16'h003C);
    dsp_rd(1'b0);
    dsp_rd(1'b1);
    chk("post_done_dout", {8'h0, cpu_dout}, 16'h0080);
    chk("post_done_irq", {15'h0, irq}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
